// File: rtl/key_debounce_multi_if.sv
// Raw button inputs and conditioned key events for key_debounce_multi.
// master = conditioner (drives events), slave = consumer (drives raw buttons in a bench).
interface key_debounce_multi_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] btn;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_repeat;
    logic              any_press;

    modport master (
        input  btn,
        output key_level, key_press, key_release, key_long, key_repeat, any_press
    );

    modport slave (
        output btn,
        input  key_level, key_press, key_release, key_long, key_repeat, any_press
    );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel key conditioner: sync, debounce, press/release/long pulses (auto-repeat under KEY_AUTOREPEAT_EN).
// Latency: steady raw edge -> key_level/key_press after 2+DEB_CYCLES clks; any_press one clk later.
// Backpressure: none; events are single-clock pulses and must be consumed when asserted.
module key_debounce_multi #(
    parameter int N_KEYS        = 4,
    parameter int ACTIVE_LOW    = 0,
    parameter int DEB_CYCLES    = 30,
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    key_debounce_multi_if.master  bus
);
    localparam logic [N_KEYS-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0]  DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LONG_MAX = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LONG_SAT = CNT_W'(LONG_CYCLES);

    if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES ||
        longint'(LONG_CYCLES) + longint'(REPEAT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_params
        $error("key_debounce_multi: illegal parameter combination");
    end

    logic [N_KEYS-1:0] sync1, sync2, s;
    logic [N_KEYS-1:0] press_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= bus.btn;
            sync2 <= sync1;
        end
    end

    assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic [CNT_W-1:0] deb_cnt, hold_cnt;
        logic level, press_q, release_q, long_q;
        logic change, fall;

        assign change = (s[i] != level) && (deb_cnt == DEB_MAX);
        assign fall   = change && level;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                level     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                // Any sample matching the accepted level restarts the stability window.
                if (s[i] == level || change) deb_cnt <= '0;
                else                         deb_cnt <= deb_cnt + 1'b1;
                if (change) level <= ~level;
                press_q   <= change && !level;
                release_q <= fall;

                // Saturating at LONG_CYCLES makes the LONG_MAX match occur once per hold.
                if (!level)                 hold_cnt <= '0;
                else if (hold_cnt != LONG_SAT) hold_cnt <= hold_cnt + 1'b1;
                long_q <= level && !fall && (hold_cnt == LONG_MAX);
            end
        end

`ifdef KEY_AUTOREPEAT_EN
        localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES - 1);
        logic [CNT_W-1:0] rep_cnt;
        logic             rep_q;

        // Repeat phase starts the clock after key_long, once the hold counter has saturated.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rep_cnt <= '0;
                rep_q   <= 1'b0;
            end else begin
                if (!level || hold_cnt != LONG_SAT || rep_cnt == REP_MAX) rep_cnt <= '0;
                else                                                      rep_cnt <= rep_cnt + 1'b1;
                rep_q <= level && !fall && (hold_cnt == LONG_SAT) && (rep_cnt == REP_MAX);
            end
        end
        assign bus.key_repeat[i] = rep_q;
`else
        assign bus.key_repeat[i] = 1'b0;
`endif

        assign bus.key_level[i]   = level;
        assign bus.key_press[i]   = press_q;
        assign bus.key_release[i] = release_q;
        assign bus.key_long[i]    = long_q;
        assign press_vec[i]       = press_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.any_press <= 1'b0;
        else          bus.any_press <= |press_vec;
    end
endmodule
